// File: rtl/hazard_if.sv
// Hazard-control bundle between the RV32 pipeline stage registers and
// the hazard controller: register numbers, write enables, MDU handshake,
// forwarding selects, stall/flush enables and the performance counters.
interface hazard_if #(
  parameter int CNT_WIDTH = 32
);

  logic [4:0]           rs1_d;
  logic [4:0]           rs2_d;
  logic [4:0]           rs1_e;
  logic [4:0]           rs2_e;
  logic [4:0]           rd_e;
  logic [1:0]           res_src_e;
  logic [4:0]           rd_m;
  logic [4:0]           rd_w;
  logic                 reg_write_m;
  logic                 reg_write_w;
  logic                 pc_src_e;
  logic                 mdu_start_e;
  logic                 mdu_done;
  logic                 cnt_clr;

  logic [1:0]           forward_a_e;
  logic [1:0]           forward_b_e;
  logic                 stall_f;
  logic                 stall_d;
  logic                 stall_e;
  logic                 flush_d;
  logic                 flush_e;
  logic                 flush_m;
  logic                 mdu_abort;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // Pipeline side: supplies register numbers and control, consumes enables.
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, rd_m, rd_w,
           reg_write_m, reg_write_w, pc_src_e, mdu_start_e, mdu_done, cnt_clr,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
           flush_d, flush_e, flush_m, mdu_abort, stall_cnt, flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, rd_m, rd_w,
           reg_write_m, reg_write_w, pc_src_e, mdu_start_e, mdu_done, cnt_clr,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
           flush_d, flush_e, flush_m, mdu_abort, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: execute-stage operand
// forwarding, load-use bubble insertion, branch flushes, multi-cycle MDU
// sequencing with a timeout abort, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  localparam int TW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(MDU_TIMEOUT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Forward select for one execute operand; memory stage beats writeback,
  // and x0 is never forwarded because it is hard-wired to zero.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  state_t               state_q, state_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 abort_q, abort_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic                 lwstall;
  logic                 mdu_stall;
  logic                 lw_eff;
  logic                 stall_f_w;
  logic                 stall_d_w;
  logic                 stall_e_w;
  logic                 flush_d_w;
  logic                 flush_e_w;
  logic                 flush_m_w;

  // Operand forwarding is purely combinational and unaffected by reset.
  always_comb begin
    hz.forward_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
    hz.forward_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
  end

  // Load in execute whose destination feeds the instruction in decode.
  always_comb begin
    lwstall = (hz.res_src_e == 2'b01) && (hz.rd_e != 5'd0) &&
              ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
  end

  // MDU FSM next state, timeout counter and the MDU freeze request.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    abort_d   = 1'b0;
    mdu_stall = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        tmo_d = '0;
        if (hz.mdu_start_e && !hz.mdu_done) begin
          mdu_stall = 1'b1;
          state_d   = ST_BUSY;
          tmo_d     = TW'(1);
        end
      end
      ST_BUSY: begin
        if (hz.mdu_done) begin
          // Result captured this cycle; done wins over a coincident timeout.
          state_d = ST_RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LIMIT) begin
          abort_d = 1'b1;
          state_d = ST_RUN;
          tmo_d   = '0;
        end else begin
          mdu_stall = 1'b1;
          tmo_d     = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end
    endcase
  end

  // Stall/flush combination: branch flush suppresses the load-use bubble,
  // and an MDU freeze suppresses it too so the held execute stage keeps
  // its MDU instruction. Everything is forced low while in reset.
  always_comb begin
    lw_eff    = lwstall && !hz.pc_src_e && !mdu_stall;
    stall_f_w = rst_n && (mdu_stall || lw_eff);
    stall_d_w = rst_n && (mdu_stall || lw_eff);
    stall_e_w = rst_n && mdu_stall;
    flush_d_w = rst_n && hz.pc_src_e;
    flush_e_w = rst_n && (hz.pc_src_e || lw_eff);
    flush_m_w = rst_n && mdu_stall;
  end

  // Drive the stall/flush enables onto the bundle.
  always_comb begin
    hz.stall_f = stall_f_w;
    hz.stall_d = stall_d_w;
    hz.stall_e = stall_e_w;
    hz.flush_d = flush_d_w;
    hz.flush_e = flush_e_w;
    hz.flush_m = flush_m_w;
  end

  // Performance counter next values; clear has priority over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_f_w) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
      if (hz.pc_src_e) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end
    end
  end

  // State register; an asynchronous reset abandons any MDU operation silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    hz.mdu_abort = abort_q;
    hz.stall_cnt = stall_cnt_q;
    hz.flush_cnt = flush_cnt_q;
  end

endmodule
